lsu_dmem_if: RTL
================

// Module: lsu_dmem_if
// PURPOSE
// - Load/store unit bridging the core's memory stage to the shared multicore data bus.
// - Arbitrates for the bus, drives word-aligned address, byte enables and write data, then waits for ack.
// - Aligns and sign/zero-extends load data into lsu_rdata, which feeds the writeback mux dmem_output input.
// - Stalls the core via lsu_stall for the whole transaction.
// PARAMETERS
// - TIMEOUT_CYCLES  255  max cycles in ARB or XFER before abort with lsu_err; 0 disables timeout
// - ADDR_W          32   address width
// PORTS
// - clk           in   1       core clock, rising edge
// - rst_n         in   1       async active-low reset
// - lsu_req       in   1       memory op valid this cycle (level; held by core while stalled)
// - lsu_we        in   1       1=store, 0=load
// - lsu_funct3    in   3       RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - lsu_addr      in   ADDR_W  byte address from ALU
// - lsu_wdata     in   32      store data (rs2), LSB-aligned
// - lsu_rdata     out  32      extended load data to writeback mux
// - lsu_stall     out  1       hold PC/pipeline while high
// - lsu_done      out  1       one-cycle pulse: transaction complete
// - lsu_err       out  1       one-cycle pulse with lsu_done: misaligned, illegal funct3 or timeout
// - bus_req       out  1       request to arbiter
// - bus_gnt       in   1       grant from arbiter
// - bus_addr      out  ADDR_W  word address (addr[1:0]=00)
// - bus_we        out  1       write strobe
// - bus_be        out  4       byte enables
// - bus_wdata     out  32      lane-replicated store data
// - bus_rdata     in   32      read data, valid with bus_ack
// - bus_ack       in   1       transfer complete
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low.
// - Reset: state=IDLE; lsu_rdata=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, lsu_done=0, lsu_err=0.
// - FSM states: IDLE, ARB, XFER, DONE.
// - IDLE: on lsu_req, check alignment: H needs addr[0]=0, W needs addr[1:0]=00; funct3 must be legal for lsu_we.
//   - Bad alignment or funct3: go DONE with err, no bus traffic.
//   - Otherwise latch addr/we/funct3/wdata, assert bus_req, go ARB.
// - ARB: hold bus_req and bus signals stable until bus_gnt=1, then XFER. bus_req stays high through XFER.
// - XFER: on bus_ack, capture extended load data into lsu_rdata (stores leave lsu_rdata unchanged),
//   drop bus_req/bus_we/bus_be next edge, go DONE.
// - DONE: lsu_done=1 for exactly one cycle, lsu_stall=0, back to IDLE. The core advances past the op this cycle.
// - lsu_stall is combinational: (lsu_req & state==IDLE) | state==ARB | state==XFER.
// - Min latency: req seen at edge0, gnt+ack both high in the first XFER cycle -> done at edge3.
// - Byte enables:
//   - B: 4'b0001<<addr[1:0]; H: 4'b0011<<addr[1:0]; W: 4'b1111.
//   - bus_wdata = {4{byte}} for B, {2{half}} for H, word for W.
// - Load extend: select lane by addr[1:0]; B/H sign-extend from bit 7/15; BU/HU zero-extend.
// - Timeout: a per-state counter resets on state entry. Reaching TIMEOUT_CYCLES in ARB or XFER
//   drops the bus request and goes DONE with lsu_err; lsu_rdata is unchanged.
// - Simultaneous gnt and ack in ARB: treat as gnt only. ack is ignored outside XFER.
// - Async reset mid-transaction aborts immediately; bus outputs go to zero in the same instant.
// - Back-to-back requests: after DONE, a new lsu_req is accepted in the IDLE cycle that follows.
// STRUCTURE
// - Shared package core_pkg:
//   - lsu_state_e enum {IDLE, ARB, XFER, DONE}
//   - funct3 localparams F3_LB/LH/LW/LBU/LHU/SB/SH/SW
// - Sub-module lsu_align: combinational be/wdata generation and load extension (keeps the FSM small).
// TESTING
// - LW addr 0x100, gnt cycle1, ack cycle2, rdata 0xDEADBEEF -> bus_be 1111, lsu_rdata 0xDEADBEEF,
//   lsu_done one pulse, stall high for 3 cycles.
// - LB addr 0x103, rdata 0x80FF_0000 -> be 1000, lsu_rdata 0xFFFFFF80.
//   LBU same -> 0x00000080.
//   LH addr 0x102 -> 0xFFFF80FF.
// - SB addr 0x201 wdata 0x12345678 -> bus_be 0010, bus_wdata 0x78787878, bus_we=1, lsu_rdata unchanged.
// - LW addr 0x102 -> no bus_req ever, lsu_err+lsu_done pulse one cycle after req.
// - gnt never asserted, TIMEOUT_CYCLES=8 -> bus_req drops after 8 ARB cycles, lsu_err pulse.
//   Then rst_n low mid-XFER -> all bus outputs 0 immediately, state IDLE.
// - Two consecutive SW then LW with gnt tied high -> each completes, second bus_req rises the cycle after first lsu_done.

Source files
------------

// File: rtl/core_pkg.sv
// Shared LSU types: FSM states, RV32I load/store funct3 codes and request legality helpers.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Store-side bus payload produced by the lane aligner.
  typedef struct packed {
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } lsu_st_lane_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word.
  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return ~off[0];
      2'b10:   return (off == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replicated write data, and load lane
// selection with sign or zero extension.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]      st_funct3_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] st_wdata_i,
  output lsu_st_lane_t    st_lane_c_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] ld_rdata_i,
  output logic [XLEN-1:0] ld_data_c_o
);

  logic [XLEN-1:0] ld_lane;

  // Byte enables shift with the offset; data is replicated so every lane carries it.
  always_comb begin : st_lane_gen
    st_lane_c_o = '0;
    case (st_funct3_i[1:0])
      2'b00: begin
        st_lane_c_o.be    = 4'b0001 << st_off_i;
        st_lane_c_o.wdata = {4{st_wdata_i[7:0]}};
      end
      2'b01: begin
        st_lane_c_o.be    = 4'b0011 << st_off_i;
        st_lane_c_o.wdata = {2{st_wdata_i[15:0]}};
      end
      default: begin
        st_lane_c_o.be    = 4'b1111;
        st_lane_c_o.wdata = st_wdata_i;
      end
    endcase
  end

  assign ld_lane = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin : ld_extend
    ld_data_c_o = ld_lane;
    case (ld_funct3_i)
      F3_LB:   ld_data_c_o = {{24{ld_lane[7]}}, ld_lane[7:0]};
      F3_LH:   ld_data_c_o = {{16{ld_lane[15]}}, ld_lane[15:0]};
      F3_LBU:  ld_data_c_o = {24'd0, ld_lane[7:0]};
      F3_LHU:  ld_data_c_o = {16'd0, ld_lane[15:0]};
      default: ld_data_c_o = ld_lane;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_if.sv
// Load/store unit: arbitrates for the shared data bus, performs one aligned transfer per
// core memory op, stalls the core meanwhile and returns extended load data.
module lsu_dmem_if
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [XLEN-1:0]   lsu_wdata,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic              lsu_err,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [BE_W-1:0]   bus_be,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_ack
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [BE_W-1:0]   bus_be_q, bus_be_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [XLEN-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic              lsu_done_q, lsu_done_d;
  logic              lsu_err_q, lsu_err_d;

  lsu_st_lane_t      st_lane;
  logic [XLEN-1:0]   ld_data;
  logic              req_ok;
  logic              to_hit;

  lsu_align u_align (
    .st_funct3_i (lsu_funct3),
    .st_off_i    (lsu_addr[1:0]),
    .st_wdata_i  (lsu_wdata),
    .st_lane_c_o (st_lane),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (bus_rdata),
    .ld_data_c_o (ld_data)
  );

  assign req_ok = f3_legal(lsu_we, lsu_funct3) && addr_aligned(lsu_funct3, lsu_addr[1:0]);
  assign to_hit = TO_EN && (cnt_q == CNT_W'(TO_LAST));

  // Next-state, bus payload latch and completion pulses.
  always_comb begin : fsm_next
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    lsu_rdata_d = lsu_rdata_q;
    lsu_done_d  = 1'b0;
    lsu_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (lsu_req) begin
          if (!req_ok) begin
            state_d    = DONE;
            lsu_done_d = 1'b1;
            lsu_err_d  = 1'b1;
          end else begin
            state_d     = ARB;
            bus_req_d   = 1'b1;
            bus_we_d    = lsu_we;
            bus_be_d    = st_lane.be;
            bus_wdata_d = st_lane.wdata;
            bus_addr_d  = {lsu_addr[ADDR_W-1:2], 2'b00};
            f3_d        = lsu_funct3;
            off_d       = lsu_addr[1:0];
          end
        end
      end
      ARB: begin
        // A grant on the final budget cycle still wins over the timeout.
        if (bus_gnt) begin
          state_d = XFER;
        end else if (to_hit) begin
          state_d    = DONE;
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          bus_be_d   = '0;
          lsu_done_d = 1'b1;
          lsu_err_d  = 1'b1;
        end
      end
      XFER: begin
        if (bus_ack || to_hit) begin
          state_d    = DONE;
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          bus_be_d   = '0;
          lsu_done_d = 1'b1;
          lsu_err_d  = ~bus_ack;
          if (bus_ack && !bus_we_q) begin
            lsu_rdata_d = ld_data;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      lsu_rdata_q <= '0;
      lsu_done_q  <= 1'b0;
      lsu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      lsu_rdata_q <= lsu_rdata_d;
      lsu_done_q  <= lsu_done_d;
      lsu_err_q   <= lsu_err_d;
    end
  end

  assign lsu_stall = (lsu_req && (state_q == IDLE)) || (state_q == ARB) || (state_q == XFER);

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_be    = bus_be_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign lsu_rdata = lsu_rdata_q;
  assign lsu_done  = lsu_done_q;
  assign lsu_err   = lsu_err_q;

endmodule
